// File: rtl/aes_mix_pkg.sv
// Shared definitions for the forward AES MixColumns engine.
//   - mix_state_e : engine FSM states (IDLE, BUSY, DONE)
//   - NUM_COLS    : columns per AES state (fixed at 4)
//   - COL_W       : bits per column, row 0 in bits [31:24]
//   - AES_POLY    : low byte of the GF(2^8) reduction polynomial 0x11B
//   - xtime/mul2/mul3 : GF(2^8) helpers used by the column transform
package aes_mix_pkg;

   localparam int unsigned NUM_COLS  = 4;
   localparam int unsigned COL_W     = 32;
   localparam int unsigned STATE_W   = NUM_COLS * COL_W;
   localparam int unsigned COL_CNT_W = $clog2(NUM_COLS);
   localparam logic [7:0]  AES_POLY  = 8'h1B;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mix_state_e;

   // Multiply by x modulo x^8+x^4+x^3+x+1; the dropped bit 7 is folded back in.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq.
//   in_valid/in_ready/data_in    : upstream state transfer (data_in column 0 = [127:96])
//   out_valid/out_ready/data_out : downstream state transfer, same column layout
//   busy                         : engine is transforming columns
//   bypass                       : only with MIXCOL_BYPASS_EN; skip the transform
// Modports: slave = engine side, master = upstream/downstream side.
interface mix_columns_seq_if;
   import aes_mix_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] data_in;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] data_out;
   logic               busy;
`ifdef MIXCOL_BYPASS_EN
   logic               bypass;

   modport slave (
      input  in_valid,
      input  data_in,
      input  bypass,
      input  out_ready,
      output in_ready,
      output out_valid,
      output data_out,
      output busy
   );

   modport master (
      output in_valid,
      output data_in,
      output bypass,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  data_out,
      input  busy
   );
`else
   modport slave (
      input  in_valid,
      input  data_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output data_out,
      output busy
   );

   modport master (
      output in_valid,
      output data_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  data_out,
      input  busy
   );
`endif

endinterface

// File: rtl/mix_column_fwd.sv
// Forward AES MixColumns on a single 32-bit column, purely combinational.
//   col_in  : input column, a0 in bits [31:24] .. a3 in bits [7:0]
//   col_out : transformed column, r0 in bits [31:24] .. r3 in bits [7:0]
// Encrypt-side mirror of the inverse column helper; the coefficient matrix is
// the circulant {2,3,1,1}.
module mix_column_fwd
   import aes_mix_pkg::*;
(
   input  logic [COL_W-1:0] col_in,
   output logic [COL_W-1:0] col_out
);

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] r0, r1, r2, r3;

   assign {a0, a1, a2, a3} = col_in;

   always_comb begin
      r0 = mul2(a0) ^ mul3(a1) ^ a2       ^ a3;
      r1 = a0       ^ mul2(a1) ^ mul3(a2) ^ a3;
      r2 = a0       ^ a1       ^ mul2(a2) ^ mul3(a3);
      r3 = mul3(a0) ^ a1       ^ a2       ^ mul2(a3);
   end

   assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential forward AES MixColumns engine.
// Accepts one 128-bit state, transforms one column per cycle through a single
// shared mix_column_fwd, then holds the result until the downstream accepts it.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mix_columns_seq_if.slave (in/out handshakes, data, busy)
// Optional build macro MIXCOL_BYPASS_EN adds bus.bypass: a state accepted with
// bypass=1 is copied straight to data_out and presented without the transform
// (final AES round).
module mix_columns_seq
   import aes_mix_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   mix_columns_seq_if.slave bus
);

   localparam logic [COL_CNT_W-1:0] LAST_COL = COL_CNT_W'(NUM_COLS - 1);

   mix_state_e           state_q, state_d;
   logic [COL_CNT_W-1:0] col_q, col_d;
   logic [STATE_W-1:0]   hold_q, hold_d;
   logic [STATE_W-1:0]   dout_q, dout_d;

   logic [COL_W-1:0]     col_in;
   logic [COL_W-1:0]     col_out;

   // Column 0 lives in the top slice, so the slice base counts down with col.
   always_comb begin
      col_in = hold_q[(NUM_COLS - 1 - int'(col_q)) * COL_W +: COL_W];
   end

   mix_column_fwd u_mix_column_fwd (
      .col_in  (col_in),
      .col_out (col_out)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      hold_d  = hold_q;
      dout_d  = dout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               hold_d = bus.data_in;
               col_d  = '0;
`ifdef MIXCOL_BYPASS_EN
               if (bus.bypass) begin
                  dout_d  = bus.data_in;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
`else
               state_d = BUSY;
`endif
            end
         end

         BUSY: begin
            dout_d[(NUM_COLS - 1 - int'(col_q)) * COL_W +: COL_W] = col_out;
            if (col_q == LAST_COL) begin
               col_d   = '0;
               state_d = DONE;
            end else begin
               col_d = col_q + 1'b1;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            col_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         hold_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         hold_q  <= hold_d;
         dout_q  <= dout_d;
      end
   end

   // Handshake outputs decode directly from the state register, so reset
   // takes effect on them without waiting for an edge.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == BUSY);
   assign bus.data_out  = dout_q;

   // A stalled result must not move.
   property p_hold_stable;
      @(posedge clk) disable iff (rst)
         (bus.out_valid && !bus.out_ready) |=> $stable(bus.data_out);
   endproperty
   a_hold_stable: assert property (p_hold_stable);

   property p_ready_excl;
      @(posedge clk) disable iff (rst)
         !(bus.in_ready && bus.out_valid);
   endproperty
   a_ready_excl: assert property (p_ready_excl);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: directed steps, a queue of expected
// states filled at the accept and drained when a result is presented.
module tb_mix_columns_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mix_columns_seq_if bus ();

   mix_columns_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [127:0] exp_q[$];

   // Reference GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Reference MixColumns on a whole state via the circulant matrix.
   function automatic logic [127:0] model(input logic [127:0] s);
      logic [7:0]   base[4];
      logic [7:0]   a[4];
      logic [7:0]   r;
      logic [127:0] o = '0;
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
         for (int rr = 0; rr < 4; rr++) begin
            r = 8'h00;
            for (int k = 0; k < 4; k++) r = r ^ gf_mul(a[k], base[(k - rr + 4) % 4]);
            o[127 - 32*c - 8*rr -: 8] = r;
         end
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input string tag);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=unexpected_output expected=empty_queue", tag);
      end else begin
         chk(tag, bus.data_out, exp_q.pop_front());
      end
   endtask

   // Present one state and complete the accept edge.
   task automatic send(input logic [127:0] d, input bit byp, input logic [127:0] expv);
      bus.data_in  = d;
      bus.in_valid = 1'b1;
`ifdef MIXCOL_BYPASS_EN
      bus.bypass   = byp;
`endif
      chk("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
      tick();
      bus.in_valid = 1'b0;
      exp_q.push_back(expv);
   endtask

   // Count edges after the accept edge until out_valid, then check the result.
   task automatic wait_out(input string tag, input int lat);
      int n = 0;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 128'(n), 128'(lat));
      pop_chk({tag, "_data"});
   endtask

   task automatic handshake(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_ready_back"}, 128'(bus.in_ready), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] v1, e1, v2, e2, v4, e4, v4b, e4b;
      logic [127:0] b2b[3];
      int acc_c[3];
      int hs_c[3];
      int idx, got;
      bit acc, hs;

      v1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      e1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      v2  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
      e2  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
      v4  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
      e4  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
      v4b = 128'hd4d4d4d5_2d26314c_00000000_00000000;
      e4b = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.data_in   = '0;
`ifdef MIXCOL_BYPASS_EN
      bus.bypass    = 1'b0;
`endif

      // Reset state.
      tick();
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_data_out", bus.data_out, 128'h0);
      rst = 1'b0;
      tick();

      // FIPS-197 column vectors.
      chk("model_selftest", model(v1), e1);
      send(v1, 1'b0, e1);
      chk("busy_after_accept", 128'(bus.busy), 128'(1));
      chk("in_ready_busy", 128'(bus.in_ready), 128'(0));
      wait_out("fips_cols", 4);
      handshake("fips_cols");

      // FIPS-197 round-1 state, with backpressure and ignored in_valid.
      send(v2, 1'b0, e2);
      bus.data_in  = 128'hffffffff_00000000_12345678_9abcdef0;
      bus.in_valid = 1'b1;
      wait_out("round1", 4);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", 128'(bus.out_valid), 128'(1));
         chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
         chk("stall_data", bus.data_out, e2);
      end
      bus.in_valid = 1'b0;
      handshake("round1");
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("no_extra_accept", {126'h0, bus.busy, bus.out_valid}, 128'h0);
      end

      // Reset on the second BUSY cycle.
      send(v4, 1'b0, e4);
      tick();
      chk("partial_busy", 128'(bus.busy), 128'(1));
      chk("partial_col0", 128'(bus.data_out[127:96]), 128'(32'hd5d5d7d6));
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("midrst_busy", 128'(bus.busy), 128'(0));
      chk("midrst_data_out", bus.data_out, 128'h0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      send(v4b, 1'b0, e4b);
      wait_out("after_rst", 4);
      handshake("after_rst");

      // Back-to-back with out_ready tied high.
      b2b[0] = {$urandom, $urandom, $urandom, $urandom};
      b2b[1] = v2;
      b2b[2] = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         acc_c[i] = -100;
         hs_c[i]  = -200;
      end
      idx = 0;
      got = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.data_in   = b2b[0];
      for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
         acc = bus.in_valid && bus.in_ready;
         hs  = bus.out_valid && bus.out_ready;
         if (hs) begin
            pop_chk("b2b_data");
            hs_c[got] = cyc;
            got++;
         end
         if (acc) begin
            exp_q.push_back(model(b2b[idx]));
            acc_c[idx] = cyc;
            idx++;
         end
         tick();
         if (acc) begin
            if (idx < 3) bus.data_in = b2b[idx];
            else bus.in_valid = 1'b0;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_count", 128'(got), 128'(3));
      chk("b2b_first_lat", 128'(hs_c[0] - acc_c[0]), 128'(5));
      chk("b2b_accept2", 128'(acc_c[1] - hs_c[0]), 128'(1));
      chk("b2b_accept3", 128'(acc_c[2] - hs_c[1]), 128'(1));
      tick();

`ifdef MIXCOL_BYPASS_EN
      // Bypass: copied unchanged, presented right after the accept edge.
      send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
           128'h00112233_44556677_8899aabb_ccddeeff);
      bus.bypass = 1'b0;
      wait_out("bypass", 0);
      handshake("bypass");
      send(v1, 1'b0, e1);
      wait_out("after_bypass", 4);
      handshake("after_bypass");
`endif

      chk("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
